// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback block.
//   XLEN / REG_ADDR_W   : datapath and register-address widths
//   F3_*                : load-type encodings carried with each load result
//   load_entry_t        : one buffered load result (destination, type, raw doubleword)
//   load_extend()       : sign/zero extension of a raw doubleword by load type
package regfile_wb_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [XLEN-1:0]       data;
    } load_entry_t;

    localparam int unsigned LOAD_ENTRY_W = $bits(load_entry_t);

    // LD and the unused 111 encoding both pass the full doubleword.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] result;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){raw[7]}}, raw[7:0]};
            F3_LH:   result = {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_LW:   result = {{(XLEN-32){raw[31]}}, raw[31:0]};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, raw[7:0]};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, raw[15:0]};
            F3_LWU:  result = {{(XLEN-32){1'b0}}, raw[31:0]};
            default: result = raw;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load results ahead of the writeback arbiter.
//   clk, rst            : clock, synchronous active-high reset (clears pointers/occupancy)
//   push, push_data     : write an entry (ignored when full)
//   pop, pop_data       : pop_data is the current head; pop removes it (ignored when empty)
//   full, empty         : occupancy flags; push and pop in one cycle leave occupancy unchanged
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_en, pop_en;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (pop_en && !push_en) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback stage: merges ALU results and buffered load results onto the
// single register-file write port.
//   clk, rst                          : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake (ready is combinational)
//   mem_valid/mem_ready/mem_rd/mem_data/mem_funct3 : load result into the load FIFO
//   we_regs/w_regs_addr/w_regs_data   : registered register-file write port
//   wb_idle                           : load FIFO empty and no write in progress
// Optional feature macro WB_FWD_EN adds read-port bypass:
//   r_regs_addr1/2, regs_data1/2 in; fwd_data1/2 out (write data when addresses match).
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic [2:0]            mem_funct3,
`ifdef WB_FWD_EN
    input  logic [REG_ADDR_W-1:0] r_regs_addr1,
    input  logic [REG_ADDR_W-1:0] r_regs_addr2,
    input  logic [XLEN-1:0]       regs_data1,
    input  logic [XLEN-1:0]       regs_data2,
    output logic [XLEN-1:0]       fwd_data1,
    output logic [XLEN-1:0]       fwd_data2,
`endif
    output logic                  we_regs,
    output logic [REG_ADDR_W-1:0] w_regs_addr,
    output logic [XLEN-1:0]       w_regs_data,
    output logic                  wb_idle
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic                    fifo_full, fifo_empty, fifo_push;
    logic [LOAD_ENTRY_W-1:0] head_bits;
    load_entry_t             head, push_entry;

    logic                    grant_alu, grant_load, starved;
    logic [CNT_W-1:0]        starve_q, starve_d;

    logic                    win_wr;
    logic [REG_ADDR_W-1:0]   win_rd;
    logic [XLEN-1:0]         win_data;

    logic                    we_regs_q;
    logic [REG_ADDR_W-1:0]   w_regs_addr_q;
    logic [XLEN-1:0]         w_regs_data_q;

    assign push_entry = '{rd: mem_rd, funct3: mem_funct3, data: mem_data};
    assign head       = load_entry_t'(head_bits);

    // No pass-through: a load always lands in the FIFO before it can be granted.
    assign mem_ready = !fifo_full && !rst;
    assign fifo_push = mem_valid && mem_ready;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LOAD_ENTRY_W)
    ) u_load_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (grant_load),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Loads win unless the ALU has been passed over STARVE_LIMIT times in a row.
    assign starved    = (starve_q == STARVE_MAX);
    assign grant_alu  = !rst && alu_valid && (fifo_empty || starved);
    assign grant_load = !rst && !fifo_empty && !grant_alu;
    assign alu_ready  = grant_alu;

    always_comb begin
        starve_d = starve_q;
        if (!alu_valid || grant_alu) begin
            starve_d = '0;
        end else if (grant_load) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_comb begin
        win_rd   = head.rd;
        win_data = load_extend(head.funct3, head.data);
        if (grant_alu) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end
        // x0 results are consumed but never written.
        win_wr = (grant_alu || grant_load) && (win_rd != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q      <= '0;
            we_regs_q     <= 1'b0;
            w_regs_addr_q <= '0;
            w_regs_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            we_regs_q <= win_wr;
            if (win_wr) begin
                w_regs_addr_q <= win_rd;
                w_regs_data_q <= win_data;
            end
        end
    end

    assign we_regs     = we_regs_q;
    assign w_regs_addr = w_regs_addr_q;
    assign w_regs_data = w_regs_data_q;
    assign wb_idle     = fifo_empty && !we_regs_q;

`ifdef WB_FWD_EN
    logic hit1, hit2;

    assign hit1      = we_regs_q && (w_regs_addr_q != '0) && (r_regs_addr1 == w_regs_addr_q);
    assign hit2      = we_regs_q && (w_regs_addr_q != '0) && (r_regs_addr2 == w_regs_addr_q);
    assign fwd_data1 = hit1 ? w_regs_data_q : regs_data1;
    assign fwd_data2 = hit2 ? w_regs_data_q : regs_data2;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic [2:0]  mem_funct3;
    logic        we_regs;
    logic [4:0]  w_regs_addr;
    logic [63:0] w_regs_data;
    logic        wb_idle;

    regfile_writeback #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_funct3  (mem_funct3),
        .we_regs     (we_regs),
        .w_regs_addr (w_regs_addr),
        .w_regs_data (w_regs_data),
        .wb_idle     (wb_idle)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Extension rule stated as "keep the low N bits, then fill above with the sign or zeros".
    function automatic logic [63:0] m_ext(input logic [2:0] f3, input logic [63:0] d);
        int          bits;
        bit          sgn;
        logic [63:0] mask, v;
        case (f3)
            3'd0:    begin bits = 8;  sgn = 1; end
            3'd1:    begin bits = 16; sgn = 1; end
            3'd2:    begin bits = 32; sgn = 1; end
            3'd4:    begin bits = 8;  sgn = 0; end
            3'd5:    begin bits = 16; sgn = 0; end
            3'd6:    begin bits = 32; sgn = 0; end
            default: begin bits = 64; sgn = 0; end
        endcase
        mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
        v = d & mask;
        if (sgn && bits < 64 && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // Behavioural model: a queue of pending loads, a starvation tally and the expected
    // state of the write port; stepped and compared once per cycle on the falling edge.
    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [63:0] data;
    } ld_t;

    ld_t         mq[$];
    int          m_starve    = 0;
    bit          m_we        = 0;
    logic [4:0]  m_addr      = '0;
    logic [63:0] m_data      = '0;
    bit          model_on    = 0;
    int          load_writes = 0;

    always @(negedge clk) begin : model
        bit          alu_win, load_win, full;
        logic [4:0]  rd;
        logic [63:0] d;
        ld_t         e;
        if (model_on) begin
            chk("we_regs", we_regs, m_we);
            chk("w_regs_addr", w_regs_addr, m_addr);
            chk("w_regs_data", w_regs_data, m_data);
            chk("wb_idle", wb_idle, (mq.size() == 0 && !m_we));
            if (we_regs && w_regs_addr >= 5'd10) load_writes++;
            if (rst) begin
                chk("alu_ready_rst", alu_ready, 0);
                chk("mem_ready_rst", mem_ready, 0);
                mq.delete();
                m_starve = 0;
                m_we     = 0;
                m_addr   = '0;
                m_data   = '0;
            end else begin
                full     = (mq.size() >= DEPTH);
                alu_win  = alu_valid && (mq.size() == 0 || m_starve == LIMIT);
                load_win = !alu_win && mq.size() != 0;
                chk("alu_ready", alu_ready, alu_win);
                chk("mem_ready", mem_ready, !full);
                rd = '0;
                d  = '0;
                if (alu_win) begin
                    rd = alu_rd;
                    d  = alu_data;
                end else if (load_win) begin
                    e  = mq.pop_front();
                    rd = e.rd;
                    d  = m_ext(e.f3, e.data);
                end
                m_we = (alu_win || load_win) && rd != 0;
                if (m_we) begin
                    m_addr = rd;
                    m_data = d;
                end
                if (mem_valid && !full) mq.push_back('{rd: mem_rd, f3: mem_funct3, data: mem_data});
                if (!alu_valid || alu_win) m_starve = 0;
                else if (load_win) m_starve++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int pushes;
    int grant_cycle;
    bit mem_took, alu_took;

    initial begin
        rst = 1; alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0; mem_funct3 = '0;
        step();
        model_on = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("reset_wb_idle", wb_idle, 1);
        chk("reset_we_regs", we_regs, 0);
        chk("reset_addr", w_regs_addr, 0);
        chk("reset_data", w_regs_data, 0);

        // ALU alone: accepted in cycle N, written in N+1.
        step(); alu_valid = 1; alu_rd = 5'd5; alu_data = 64'h1234;
        @(negedge clk); chk("alu_ready_n", alu_ready, 1);
        step(); alu_valid = 0;
        @(negedge clk);
        chk("alu_we_n1", we_regs, 1);
        chk("alu_addr_n1", w_regs_addr, 5);
        chk("alu_data_n1", w_regs_data, 64'h1234);
        step();
        @(negedge clk); chk("alu_we_one_cycle", we_regs, 0);

        // LB then LBU of 0x80: pushed at N, written at N+2.
        step(); mem_valid = 1; mem_rd = 5'd3; mem_data = 64'h80; mem_funct3 = 3'b000;
        @(negedge clk); chk("lb_mem_ready", mem_ready, 1);
        step(); mem_valid = 0;
        @(negedge clk); chk("lb_not_at_n1", we_regs, 0);
        step();
        @(negedge clk);
        chk("lb_we", we_regs, 1);
        chk("lb_addr", w_regs_addr, 3);
        chk("lb_data", w_regs_data, 64'hFFFF_FFFF_FFFF_FF80);
        step(); mem_valid = 1; mem_rd = 5'd4; mem_data = 64'h80; mem_funct3 = 3'b100;
        step(); mem_valid = 0;
        step();
        @(negedge clk);
        chk("lbu_addr", w_regs_addr, 4);
        chk("lbu_data", w_regs_data, 64'h80);

        // Every load type back to back.
        for (int f = 0; f < 8; f++) begin
            step(); mem_valid = 1; mem_rd = 5'(16 + f); mem_funct3 = 3'(f);
            mem_data = 64'hFEDC_BA98_8765_8321;
        end
        step(); mem_valid = 0;
        step();
        @(negedge clk); chk("lw_pin", m_ext(3'b010, 64'hFEDC_BA98_8765_8321), 64'hFFFF_FFFF_8765_8321);
        step(); step();

        // Contention: loads every cycle with the ALU held; ALU forced on the 5th contention
        // cycle, after which the FIFO fills and mem_ready drops.
        load_writes = 0; pushes = 0; grant_cycle = 0;
        step(); mem_valid = 1; mem_funct3 = 3'b011; mem_rd = 5'd10; mem_data = 64'd100;
        alu_rd = 5'd7; alu_data = 64'hA1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c > 0 && alu_ready && grant_cycle == 0) grant_cycle = c;
            if (c == 6) chk("mem_ready_full", mem_ready, 0);
            mem_took = mem_valid && mem_ready;
            alu_took = alu_valid && alu_ready;
            step();
            alu_valid = 1;
            if (mem_took) begin
                pushes++;
                mem_rd   = 5'(10 + pushes);
                mem_data = 64'(100 + pushes);
            end
            if (alu_took) alu_data = alu_data + 64'd1;
        end
        mem_valid = 0; alu_valid = 0;
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        chk("starve_grant_cycle", grant_cycle, 5);
        chk("loads_written", load_writes, pushes);

        // rd == 0: consumed, never written.
        step(); alu_valid = 1; alu_rd = 5'd0; alu_data = 64'hFFFF;
        @(negedge clk); chk("x0_alu_ready", alu_ready, 1);
        step(); alu_valid = 0;
        @(negedge clk); chk("x0_no_write", we_regs, 0);

        // Reset with two loads buffered.
        step(); mem_valid = 1; mem_rd = 5'd20; mem_data = 64'd500; alu_rd = 5'd8;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            mem_took = mem_valid && mem_ready;
            step();
            alu_valid = 1;
            if (mem_took) begin
                mem_rd   = mem_rd + 5'd1;
                mem_data = mem_data + 64'd1;
            end
        end
        rst = 1; mem_valid = 0; alu_valid = 0;
        @(negedge clk); chk("pre_reset_busy", wb_idle, 0);
        step(); rst = 0;
        @(negedge clk);
        chk("post_reset_idle", wb_idle, 1);
        chk("post_reset_we", we_regs, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk); chk("no_write_after_reset", we_regs, 0);
        end

        step();
        model_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, giving load-result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, giving consecutive load grants before the ALU is forced through.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port alu_valid, input, 1, ALU result offered.
REQ-006 SHALL have port alu_ready, output, 1, ALU result accepted this cycle.
REQ-007 SHALL have alu_rd (input, 5) and alu_data (input, 64), the ALU destination and result.
REQ-008 SHALL have port mem_valid, input, 1, load result offered.
REQ-009 SHALL have port mem_ready, output, 1, load FIFO can accept.
REQ-010 SHALL have mem_rd (input, 5), mem_data (input, 64, raw doubleword) and mem_funct3 (input, 3, load type).
REQ-011 SHALL have we_regs (output, 1), w_regs_addr (output, 5) and w_regs_data (output, 64), driving the register-file write port.
REQ-012 SHALL have port wb_idle, output, 1, high when the FIFO is empty and we_regs is low.

Function
REQ-013 SHALL complete a source transfer on any cycle where valid and ready are both high.
REQ-014 SHALL assert mem_ready exactly when the FIFO is not full, independent of a same-cycle pop; there is no pass-through path.
REQ-015 SHALL drive alu_ready combinationally, high only when alu_valid is high and the ALU wins arbitration.
REQ-016 SHALL arbitrate each cycle between the FIFO head (if non-empty) and alu_valid, with load priority.
REQ-017 SHALL increment a starvation counter on each load grant while alu_valid is high, and clear it on an ALU grant or whenever alu_valid is low.
REQ-018 SHALL grant the ALU when the counter equals STARVE_LIMIT and both sources request.
REQ-019 SHALL register the winner into the output stage: an ALU accepted in cycle N writes in N+1; a load pushed into an empty FIFO in cycle N writes at N+2 at the earliest.
REQ-020 SHALL hold we_regs high for exactly one cycle per granted transfer with rd!=0, and drive we_regs low when nothing is granted.
REQ-021 SHALL consume a transfer with rd==0 normally but leave we_regs low, with w_regs_addr/w_regs_data unchanged.
REQ-022 SHALL extend loads at FIFO pop from the low bits of mem_data:
- 000 LB: sign-extend 8 bits
- 001 LH: sign-extend 16 bits
- 010 LW: sign-extend 32 bits
- 011 LD and 111: pass all 64 bits
- 100 LBU / 101 LHU / 110 LWU: zero-extend 8 / 16 / 32 bits
REQ-023 SHALL preserve load order (FIFO) and ALU order.
REQ-024 SHALL allow a FIFO push and pop in the same cycle, with occupancy unchanged.

Reset
REQ-025 SHALL, while rst is high at a clock edge, clear we_regs, w_regs_addr, w_regs_data, the FIFO pointers and occupancy, and the starvation counter to 0.
REQ-026 SHALL force alu_ready and mem_ready low while rst is high.
REQ-027 SHALL drop in-flight FIFO entries on mid-operation reset and produce no write for them afterwards.
REQ-028 SHALL have wb_idle equal to 1 in the cycle after reset.

Configuration
REQ-029 SHALL, when WB_FWD_EN is defined, add inputs r_regs_addr1/2 (5) and regs_data1/2 (64) and outputs fwd_data1/2 (64).
REQ-030 SHALL, with WB_FWD_EN defined, make fwd_dataN equal w_regs_data when we_regs is high and r_regs_addrN == w_regs_addr != 0, and otherwise regs_dataN (combinational).
REQ-031 SHALL, when WB_FWD_EN is undefined, omit these ports and the logic entirely.

Structure
REQ-032 SHALL place XLEN=64, REG_ADDR_W=5 and the funct3 load-type constants in shared package regfile_wb_pkg.
REQ-033 SHALL implement the load buffer as sub-module wb_fifo (parameterised depth and width, synchronous reset), instantiated once.

Verification
REQ-034 SHALL cover: ALU only, alu_valid=1, rd=5, data=0x1234, cycle 10 -> alu_ready=1 at 10; we_regs=1, addr=5, data=0x1234 at 11.
REQ-035 SHALL cover: load LB, mem_data=0x80, rd=3 -> w_regs_data=0xFFFF_FFFF_FFFF_FF80; the LBU variant -> 0x80.
REQ-036 SHALL cover: loads every cycle plus alu_valid held -> ALU granted on the 5th contention cycle (STARVE_LIMIT=4); load order intact.
REQ-037 SHALL cover: mem_valid held with ALU priority forced -> mem_ready low after 2 pushes, no entry lost or duplicated.
REQ-038 SHALL cover: ALU rd=0, data=0xFFFF -> alu_ready=1, we_regs stays 0.
REQ-039 SHALL cover: rst pulsed with 2 FIFO entries -> no write afterwards, wb_idle=1 next cycle.
